uart_rx_capture: RTL and testbench

Parametrised, synthesizable UART receive/capture block; the next generation of the bench UART decoder. It samples a serial line with a run-time programmable bit period and configurable frame format (data bits, parity, stop bits). Received characters, with per-character parity/framing error flags, are buffered in a show-ahead FIFO with a valid/ready drain interface. It serves both as the bench-side monitor on `uart0_stx_pad_o` and as a reusable SoC receiver core on the Wishbone clock.

---
 rtl/uart_rx_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture.sv
// UART receiver: synchronizer, frame FSM and show-ahead capture FIFO.
// Run-time bit period, static frame format, per-entry parity/framing flags.
module uart_rx_capture #(
    parameter int CLK_DIV_DEFAULT = 434,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int FIFO_AW         = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 rx_i,
    input  logic [15:0]          clk_div_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_perr_o,
    output logic                 rx_ferr_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [FIFO_AW:0]     fifo_level_o,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic s1_q, s2_q, dly_q;
    logic rx_s, fall;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 sone_q, sone_d;
    logic [15:0]          div_sel, div_eff;
    logic                 tick, par_exp, ferr_n;
    logic                 push, brk;
    logic [EW-1:0]        push_data;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   lvl_q, lvl_d;
    logic               ovr_q, brk_q;
    logic               full, pop, wr_en, valid;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            dly_q <= 1'b1;
        end else begin
            s1_q  <= rx_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign rx_s = s2_q;
    assign fall = dly_q & ~s2_q;

    assign div_sel = (clk_div_i == 16'd0) ? 16'(CLK_DIV_DEFAULT) : clk_div_i;
    assign div_eff = (div_sel < 16'd4) ? 16'd4 : div_sel;

    assign tick    = (cnt_q == 16'd0);
    assign par_exp = (PARITY == 2) ? ^shift_q : ~^shift_q;
    assign ferr_n  = ferr_q | ~rx_s;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_WAIT_HIGH;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            sone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            sone_q  <= sone_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        sone_d    = sone_q;
        push      = 1'b0;
        brk       = 1'b0;
        push_data = {ferr_n, perr_q, shift_q};
        unique case (state_q)
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                    div_d   = div_eff;
                    cnt_d   = {1'b0, div_eff[15:1]};
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = div_q - 16'd1;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    sone_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = div_q - 16'd1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    perr_d  = rx_s ^ par_exp;
                    cnt_d   = div_q - 16'd1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    ferr_d = ferr_n;
                    sone_d = sone_q | rx_s;
                    cnt_d  = div_q - 16'd1;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        // Break: all-zero data and no stop sample ever high
                        push    = 1'b1;
                        brk     = (shift_q == '0) & ~(sone_q | rx_s);
                        state_d = brk ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: state_d = S_WAIT_HIGH;
        endcase
    end

    assign valid = (lvl_q != '0);
    assign full  = (lvl_q == (FIFO_AW+1)'(DEPTH));
    assign pop   = valid & rx_ready_i;
    assign wr_en = push & (~full | pop);

    always_comb begin
        lvl_d = lvl_q;
        if (wr_en && !pop) lvl_d = lvl_q + 1'b1;
        if (!wr_en && pop) lvl_d = lvl_q - 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
            ovr_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            lvl_q <= lvl_d;
            brk_q <= brk;
            if (push && !wr_en) ovr_q <= 1'b1;
            else if (overrun_clr_i) ovr_q <= 1'b0;
        end
    end

    assign rx_valid_o   = valid;
    assign {rx_ferr_o, rx_perr_o, rx_data_o} = valid ? mem_q[rd_q] : '0;
    assign fifo_level_o = lvl_q;
    assign overrun_o    = ovr_q;
    assign break_o      = brk_q;
    assign busy_o       = (state_q != S_WAIT_HIGH) && (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture: 8N1 and 8E1 instances,
// expected entries queued at stimulus time, checked by a pop monitor.
module tb_uart_rx_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        rxp = 1'b1;
    logic [15:0] clk_div = 16'd0;
    logic        ready = 1'b0;
    logic        clr = 1'b0;

    logic [7:0] data_a, data_p;
    logic       perr_a, ferr_a, valid_a, ovr_a, brk_a, busy_a;
    logic       perr_p, ferr_p, valid_p, ovr_p, brk_p, busy_p;
    logic [4:0] lvl_a, lvl_p;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    int t0   = 0;
    int vrise_cyc = -1;
    int brk_cnt = 0;
    int npop_a = 0;
    logic vprev = 1'b0;
    logic [7:0] last_pop = '0;
    logic [9:0] q_a[$];
    logic [9:0] q_p[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_capture #(
        .CLK_DIV_DEFAULT(434), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_AW(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .clk_div_i(clk_div),
        .rx_data_o(data_a), .rx_perr_o(perr_a), .rx_ferr_o(ferr_a),
        .rx_valid_o(valid_a), .rx_ready_i(ready), .fifo_level_o(lvl_a),
        .overrun_o(ovr_a), .overrun_clr_i(clr), .break_o(brk_a),
        .busy_o(busy_a)
    );

    uart_rx_capture #(
        .CLK_DIV_DEFAULT(434), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_AW(4)
    ) dut_p (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rxp), .clk_div_i(clk_div),
        .rx_data_o(data_p), .rx_perr_o(perr_p), .rx_ferr_o(ferr_p),
        .rx_valid_o(valid_p), .rx_ready_i(ready), .fifo_level_o(lvl_p),
        .overrun_o(ovr_p), .overrun_clr_i(clr), .break_o(brk_p),
        .busy_o(busy_p)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Pop monitor: compares every consumed head against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && !vprev) vrise_cyc = cyc;
            vprev = valid_a;
            if (brk_a) brk_cnt++;
            if (valid_a && ready) begin
                ncmp++;
                npop_a++;
                last_pop = data_a;
                if (q_a.size() == 0) begin
                    nerr++;
                    $display("FAIL pop_a: got %0h, want none", {ferr_a, perr_a, data_a});
                end else begin
                    logic [9:0] e;
                    e = q_a.pop_front();
                    if ({ferr_a, perr_a, data_a} !== e) begin
                        nerr++;
                        $display("FAIL pop_a: got %0h, want %0h", {ferr_a, perr_a, data_a}, e);
                    end
                end
            end
            if (valid_p && ready) begin
                ncmp++;
                if (q_p.size() == 0) begin
                    nerr++;
                    $display("FAIL pop_p: got %0h, want none", {ferr_p, perr_p, data_p});
                end else begin
                    logic [9:0] e;
                    e = q_p.pop_front();
                    if ({ferr_p, perr_p, data_p} !== e) begin
                        nerr++;
                        $display("FAIL pop_p: got %0h, want %0h", {ferr_p, perr_p, data_p}, e);
                    end
                end
            end
        end else begin
            vprev = 1'b0;
        end
    end

    task automatic drv(input bit p, input logic v);
        if (p) rxp = v;
        else rx = v;
    endtask

    task automatic hold(input int dv);
        repeat (dv) @(posedge clk);
        #1;
    endtask

    // One frame, LSB first; pb < 0 means no parity bit
    task automatic send(input bit p, input logic [7:0] d, input int pb,
                        input logic stopv, input int dv);
        @(posedge clk);
        #1;
        drv(p, 1'b0);
        t0 = cyc;
        hold(dv);
        for (int i = 0; i < 8; i++) begin
            drv(p, d[i]);
            hold(dv);
        end
        if (pb >= 0) begin
            drv(p, pb[0]);
            hold(dv);
        end
        drv(p, stopv);
        hold(dv);
        drv(p, 1'b1);
    endtask

    task automatic wait_empty(input string name, input int bound);
        int n;
        n = 0;
        while ((valid_a || valid_p || q_a.size() != 0 || q_p.size() != 0)
               && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n >= bound), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_perr", 32'(perr_a), 32'd0);
        chk("rst_ferr", 32'(ferr_a), 32'd0);
        chk("rst_level", 32'(lvl_a), 32'd0);
        chk("rst_ovr", 32'(ovr_a), 32'd0);
        chk("rst_brk", 32'(brk_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // 0x55 at D=434, timing of valid
        q_a.push_back({1'b0, 1'b0, 8'h55});
        send(1'b0, 8'h55, -1, 1'b1, 434);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t_valid_lat", 32'(vrise_cyc - t0), 32'd4127);
        chk("t_level1", 32'(lvl_a), 32'd1);
        chk("t_head55", 32'(data_a), 32'h55);
        ready = 1'b1;
        wait_empty("drain1", 50);

        // Even parity: 0xA3 has four ones, so the correct bit is 0
        clk_div = 16'd16;
        q_p.push_back({1'b0, 1'b1, 8'hA3});
        send(1'b1, 8'hA3, 1, 1'b1, 16);
        q_p.push_back({1'b0, 1'b0, 8'hA3});
        send(1'b1, 8'hA3, 0, 1'b1, 16);
        wait_empty("drain_par", 100);

        // Framing error, then break
        q_a.push_back({1'b1, 1'b0, 8'h41});
        send(1'b0, 8'h41, -1, 1'b0, 16);
        hold(32);
        brk_cnt = 0;
        npop_a = 0;
        q_a.push_back({1'b1, 1'b0, 8'h00});
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(12 * 16);
        @(negedge clk);
        chk("brk_pulses", 32'(brk_cnt), 32'd1);
        chk("brk_entries", 32'(npop_a), 32'd1);
        chk("brk_busy", 32'(busy_a), 32'd0);
        rx = 1'b1;
        hold(40);
        chk("brk_after_hi", 32'(npop_a), 32'd1);
        wait_empty("drain_brk", 50);

        // Overrun: 17 characters into a 16-deep FIFO
        ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q_a.push_back({2'b00, 8'(i)});
            send(1'b0, 8'(i), -1, 1'b1, 16);
        end
        hold(5);
        @(negedge clk);
        chk("ovr_level", 32'(lvl_a), 32'd16);
        chk("ovr_flag", 32'(ovr_a), 32'd1);
        chk("ovr_head", 32'(data_a), 32'h00);
        ready = 1'b1;
        wait_empty("drain_ovr", 100);
        chk("ovr_last", 32'(last_pop), 32'h0F);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 32'(ovr_a), 32'd0);

        // Glitch of 100 cycles at D=434
        clk_div = 16'd0;
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(50);
        chk("gl_busy", 32'(busy_a), 32'd1);
        hold(50);
        rx = 1'b1;
        hold(600);
        chk("gl_idle", 32'(busy_a), 32'd0);
        chk("gl_level", 32'(lvl_a), 32'd0);

        // Reset in the middle of a frame flushes FIFO and frame
        clk_div = 16'd16;
        ready = 1'b0;
        send(1'b0, 8'h33, -1, 1'b1, 16);
        hold(4);
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(16 * 4);
        rst = 1'b1;
        rx = 1'b1;
        hold(3);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_lvl", 32'(lvl_a), 32'd0);
        hold(20);
        q_a.push_back({2'b00, 8'h7E});
        send(1'b0, 8'h7E, -1, 1'b1, 16);
        hold(5);
        chk("mid_rst_lvl1", 32'(lvl_a), 32'd1);
        chk("mid_rst_head", 32'(data_a), 32'h7E);
        ready = 1'b1;
        wait_empty("drain_rst", 50);

        hold(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
